// File: rtl/prefetcher_pkg.sv
// Shared definitions for the prefetcher blocks: queue opcodes, framing error
// codes and AXI response encodings.
package prefetcher_pkg;

    // Opcodes understood by the prefetcher data-queue arbiter.
    localparam logic [2:0] OP_NOP              = 3'd0;
    localparam logic [2:0] OP_RD_REQ_PREF      = 3'd1;
    localparam logic [2:0] OP_RD_REQ_MASTER    = 3'd2;
    localparam logic [2:0] OP_RD_DATA_SLAVE    = 3'd3;
    localparam logic [2:0] OP_RD_DATA_PROMISE  = 3'd4;

    // Burst framing check outcome for one delivered beat.
    typedef enum logic [1:0] {
        ERR_NONE          = 2'd0,
        ERR_LAST_UNEXPECT = 2'd1,  // rlast seen before the final beat index
        ERR_LAST_MISSING  = 2'd2   // final beat index reached without rlast
    } frame_err_e;

    // AXI read response encodings.
    localparam logic [1:0] RRESP_OKAY = 2'b00;

endpackage

// File: rtl/r_skid_buffer.sv
// Generic 2-entry valid/ready buffer. Writes land in the entry at wr_ptr,
// reads present the entry at rd_ptr; both pointers are one bit wide and the
// occupancy is tracked explicitly so full and empty are unambiguous.
module r_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign valid = (count != 2'd0);
    assign do_wr = wr_en & (count != 2'd2);
    assign do_rd = rd_en & valid;

    // Empty buffer reads as zero so downstream data is clean while idle.
    assign rd_data = valid ? mem[rd_ptr] : '0;

    // Storage, pointers and occupancy; simultaneous write and read keeps occupancy.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            // NOTE: the two storage entries are reset too; a reset must discard
            // buffered beats, and at two entries the reset cost is negligible.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prefetch_r_responder.sv
// Pops ready blocks out of the prefetcher data queue (readDataPromise), holds
// them in a 2-entry skid buffer and drives them onto the AXI R channel with
// full rready backpressure. Also checks burst framing and counts beats/bursts.
module prefetch_r_responder
    import prefetcher_pkg::*;
#(
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int ID_WIDTH             = 6,
    parameter int CNT_WIDTH            = 16,
    localparam int DATA_BITS           = (1 << LOG_BLOCK_DATA_BYTES) * 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       q_valid,
    input  logic [DATA_BITS-1:0]       q_data,
    input  logic                       q_last,
    output logic                       q_pop,
    input  logic                       q_popGrant,
    input  logic [BURST_LEN_WIDTH-1:0] crs_burstLen,
    input  logic [ID_WIDTH-1:0]        crs_rid,
    output logic                       m_rvalid,
    output logic [DATA_BITS-1:0]       m_rdata,
    output logic                       m_rlast,
    output logic [ID_WIDTH-1:0]        m_rid,
    output logic [1:0]                 m_rresp,
    input  logic                       m_rready,
    output logic [CNT_WIDTH-1:0]       beatCnt,
    output logic [CNT_WIDTH-1:0]       burstCnt,
    output logic                       lastErr,
    output logic                       busy
);

    logic [1:0]                 occupancy;
    logic                       buf_valid;
    logic [DATA_BITS:0]         buf_out;
    logic                       capture;
    logic                       r_fire;
    logic [BURST_LEN_WIDTH-1:0] bic;
    logic [BURST_LEN_WIDTH-1:0] last_idx;
    frame_err_e                 frame_err;

    // Request a pop only when a grant could be absorbed even if the master
    // stalls this cycle, so a granted beat never has to be dropped.
    assign q_pop   = q_valid & (occupancy != 2'd2);
    assign capture = q_pop & q_popGrant;
    assign r_fire  = m_rvalid & m_rready;

    r_skid_buffer #(
        .WIDTH (DATA_BITS + 1)
    ) u_skid (
        .clk     (clk),
        .resetN  (resetN),
        .wr_en   (capture),
        .wr_data ({q_last, q_data}),
        .rd_en   (m_rready),
        .rd_data (buf_out),
        .valid   (buf_valid),
        .count   (occupancy)
    );

    assign m_rvalid = buf_valid;
    assign m_rlast  = buf_out[DATA_BITS];
    assign m_rdata  = buf_out[DATA_BITS-1:0];
    assign m_rid    = buf_valid ? crs_rid : '0;
    assign m_rresp  = RRESP_OKAY;
    assign busy     = buf_valid | (bic != '0);

    // A burst length of zero behaves as a single-beat burst.
    assign last_idx = (crs_burstLen == '0) ? '0 : crs_burstLen - BURST_LEN_WIDTH'(1);

    // Classify the beat at the head of the buffer against the expected framing.
    always_comb begin
        // NOTE: default first so every path assigns frame_err and no latch forms.
        frame_err = ERR_NONE;
        if (m_rlast && (bic != last_idx)) begin
            frame_err = ERR_LAST_UNEXPECT;
        end else if (!m_rlast && (bic == last_idx)) begin
            frame_err = ERR_LAST_MISSING;
        end
    end

    // Beat-in-burst tracking, statistics and the sticky framing error, all
    // updated on each R handshake.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bic      <= '0;
            beatCnt  <= '0;
            burstCnt <= '0;
            lastErr  <= 1'b0;
        end else if (r_fire) begin
            beatCnt <= beatCnt + CNT_WIDTH'(1);
            if (m_rlast) begin
                burstCnt <= burstCnt + CNT_WIDTH'(1);
                bic      <= '0;
            end else begin
                bic <= bic + BURST_LEN_WIDTH'(1);
            end
            if (frame_err != ERR_NONE) begin
                lastErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prefetch_r_responder.sv
// Directed bench for prefetch_r_responder. The bench plays the data queue
// from a source list of beats and checks every R handshake against that list
// in order, plus hand-computed counter and status values.
module tb_prefetch_r_responder;

    localparam int DW  = 512;
    localparam int BLW = 8;
    localparam int IDW = 6;
    localparam int CW  = 16;
    localparam logic [IDW-1:0] RID = 6'h2B;

    logic           clk;
    logic           resetN;
    logic           q_valid;
    logic [DW-1:0]  q_data;
    logic           q_last;
    logic           q_pop;
    logic           q_popGrant;
    logic [BLW-1:0] crs_burstLen;
    logic [IDW-1:0] crs_rid;
    logic           m_rvalid;
    logic [DW-1:0]  m_rdata;
    logic           m_rlast;
    logic [IDW-1:0] m_rid;
    logic [1:0]     m_rresp;
    logic           m_rready;
    logic [CW-1:0]  beatCnt;
    logic [CW-1:0]  burstCnt;
    logic           lastErr;
    logic           busy;

    prefetch_r_responder #(
        .LOG_BLOCK_DATA_BYTES (6),
        .BURST_LEN_WIDTH      (BLW),
        .ID_WIDTH             (IDW),
        .CNT_WIDTH            (CW)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .q_valid      (q_valid),
        .q_data       (q_data),
        .q_last       (q_last),
        .q_pop        (q_pop),
        .q_popGrant   (q_popGrant),
        .crs_burstLen (crs_burstLen),
        .crs_rid      (crs_rid),
        .m_rvalid     (m_rvalid),
        .m_rdata      (m_rdata),
        .m_rlast      (m_rlast),
        .m_rid        (m_rid),
        .m_rresp      (m_rresp),
        .m_rready     (m_rready),
        .beatCnt      (beatCnt),
        .burstCnt     (burstCnt),
        .lastErr      (lastErr),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] src_data [64];
    logic          src_last [64];
    int            src_n = 0;
    int            q_idx = 0;   // next beat the queue offers
    int            r_idx = 0;   // next beat expected on R
    logic          q_en  = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int i);
        logic [DW-1:0] d;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = {i[15:0], j[15:0]} ^ 32'h5A5A_0000;
        return d;
    endfunction

    task automatic drive_q();
        q_valid = q_en && (q_idx < src_n);
        q_data  = (q_idx < src_n) ? src_data[q_idx] : '0;
        q_last  = (q_idx < src_n) ? src_last[q_idx] : 1'b0;
    endtask

    task automatic push(input logic last);
        src_data[src_n] = mk_data(src_n);
        src_last[src_n] = last;
        src_n++;
        drive_q();
    endtask

    // Appends n beats framed as bursts of blen beats.
    task automatic load(input int n, input int blen);
        for (int k = 0; k < n; k++) push(((k + 1) % blen) == 0);
    endtask

    // One clock: sample pre-edge, step the edge, update queue model after it.
    task automatic tick();
        logic pop_fire;
        logic r_fire;
        #1;
        pop_fire = q_pop & q_popGrant;
        r_fire   = m_rvalid & m_rready;
        if (r_fire) begin
            check($sformatf("rdata[%0d]", r_idx), m_rdata, src_data[r_idx]);
            check($sformatf("rlast[%0d]", r_idx), m_rlast, src_last[r_idx]);
            check("rid", m_rid, RID);
            check("rresp", m_rresp, 2'b00);
            r_idx++;
        end
        @(posedge clk);
        #1;
        if (pop_fire) q_idx++;
        drive_q();
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (r_idx < target && n < budget) begin
            tick();
            n++;
        end
        check("beats_delivered", r_idx, target);
    endtask

    initial begin
        int base;
        resetN       = 1'b0;
        q_valid      = 1'b0;
        q_data       = '0;
        q_last       = 1'b0;
        q_popGrant   = 1'b0;
        crs_burstLen = 8'd4;
        crs_rid      = RID;
        m_rready     = 1'b0;
        #23;
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_rvalid", m_rvalid, 0);
        check("rst_rdata", m_rdata, 0);
        check("rst_rid", m_rid, 0);
        check("rst_rlast", m_rlast, 0);
        check("rst_beatCnt", beatCnt, 0);
        check("rst_burstCnt", burstCnt, 0);
        check("rst_lastErr", lastErr, 0);
        check("rst_busy", busy, 0);
        check("rst_q_pop", q_pop, 0);

        // Single burst of 4, grants every cycle, no backpressure
        q_en = 1'b1; q_popGrant = 1'b1; m_rready = 1'b1;
        load(4, 4);
        #1;
        check("t1_q_pop", q_pop, 1);
        check("t1_rvalid_pre", m_rvalid, 0);
        tick();
        check("t1_rvalid_lat1", m_rvalid, 1);
        check("t1_rdata_first", m_rdata, src_data[0]);
        run_until(4, 20);
        check("t1_beatCnt", beatCnt, 4);
        check("t1_burstCnt", burstCnt, 1);
        check("t1_lastErr", lastErr, 0);
        check("t1_busy", busy, 0);

        // Backpressure: master stalls for 5 cycles
        base = r_idx;
        m_rready = 1'b0;
        load(4, 4);
        tick();
        check("t2_rvalid", m_rvalid, 1);
        tick();
        for (int c = 0; c < 3; c++) begin
            check("t2_q_pop_full", q_pop, 0);
            check("t2_rdata_held", m_rdata, src_data[base]);
            check("t2_rvalid_held", m_rvalid, 1);
            tick();
        end
        check("t2_busy", busy, 1);
        check("t2_beatCnt_stalled", beatCnt, 4);
        m_rready = 1'b1;
        run_until(base + 4, 20);
        check("t2_beatCnt", beatCnt, 8);
        check("t2_burstCnt", burstCnt, 2);

        // Grant without a pop request is ignored
        q_en = 1'b0; drive_q();
        tick(); tick();
        check("t3_idle_grant_rvalid", m_rvalid, 0);
        check("t3_idle_grant_beatCnt", beatCnt, 8);

        // Grant withheld for 3 cycles, then given once
        base = r_idx;
        q_en = 1'b1; q_popGrant = 1'b0;
        load(4, 4);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t3_q_pop_req", q_pop, 1);
            check("t3_rvalid_nogrant", m_rvalid, 0);
            tick();
        end
        q_popGrant = 1'b1;
        tick();
        check("t3_rvalid_after_grant", m_rvalid, 1);
        check("t3_rdata_after_grant", m_rdata, src_data[base]);
        run_until(base + 4, 20);
        check("t3_beatCnt", beatCnt, 12);
        check("t3_burstCnt", burstCnt, 3);
        check("t3_lastErr", lastErr, 0);

        // Framing error: rlast on beat 2 of a 4-beat burst, then a good burst
        base = r_idx;
        push(1'b0);
        push(1'b1);
        load(4, 4);
        run_until(base + 1, 20);
        check("t4_lastErr_beat1", lastErr, 0);
        run_until(base + 2, 20);
        check("t4_lastErr_set", lastErr, 1);
        run_until(base + 6, 20);
        check("t4_lastErr_sticky", lastErr, 1);
        check("t4_beatCnt", beatCnt, 18);
        check("t4_burstCnt", burstCnt, 5);

        // Sustained throughput: 16 beats in 16 consecutive cycles
        base = r_idx;
        load(16, 4);
        tick();
        for (int c = 0; c < 16; c++) begin
            check("t5_rvalid_streaming", m_rvalid, 1);
            tick();
        end
        check("t5_delivered_16", r_idx - base, 16);
        check("t5_rvalid_drained", m_rvalid, 0);
        check("t5_beatCnt", beatCnt, 34);
        check("t5_burstCnt", burstCnt, 9);

        // Reset with two beats buffered mid-burst
        m_rready = 1'b0;
        load(4, 4);
        tick(); tick(); tick();
        check("t6_busy_pre", busy, 1);
        check("t6_rvalid_pre", m_rvalid, 1);
        #2;
        resetN = 1'b0;
        #1;
        check("t6_rst_rvalid", m_rvalid, 0);
        check("t6_rst_beatCnt", beatCnt, 0);
        check("t6_rst_burstCnt", burstCnt, 0);
        check("t6_rst_lastErr", lastErr, 0);
        check("t6_rst_busy", busy, 0);
        q_en = 1'b0; drive_q();
        repeat (2) @(posedge clk);
        #3;
        resetN = 1'b1;
        @(posedge clk);
        #1;
        // The interrupted burst is abandoned; start a fresh one.
        q_idx = src_n;
        r_idx = src_n;
        base  = r_idx;
        q_en = 1'b1; m_rready = 1'b1;
        load(4, 4);
        run_until(base + 4, 20);
        check("t6_beatCnt", beatCnt, 4);
        check("t6_burstCnt", burstCnt, 1);
        check("t6_lastErr", lastErr, 0);
        check("t6_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/prefetch_r_responder.md
Name: prefetch_r_responder

Overview:
- Downstream consumer of the prefetcher data queue.
- Pulls ready blocks out of the queue by requesting readDataPromise pops (opcode 4).
- Buffers popped beats in a 2-entry skid buffer and presents them on the master-facing AXI R channel with full rready backpressure.
- Checks burst framing (last vs. configured burst length) and counts returned beats/bursts for CRS visibility.

Parameters:
- LOG_BLOCK_DATA_BYTES, 6, log2 of block size in bytes; data width DATA_BITS = (1<<LOG_BLOCK_DATA_BYTES)*8.
- BURST_LEN_WIDTH, 8, width of burst-length and beat counters.
- ID_WIDTH, 6, AXI RID width.
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  in  1  clock.
- resetN  in  1  reset, asynchronous, active-low.
- q_valid  in  1  queue has a poppable beat (queue's pr_r_valid).
- q_data  in  DATA_BITS  head beat data (queue's respData), combinational, pre-edge value.
- q_last  in  1  head beat last flag (queue's respLast).
- q_pop  out  1  request to issue opcode 4 this cycle.
- q_popGrant  in  1  opcode arbiter accepted q_pop this cycle (queue updates at this edge).
- crs_burstLen  in  BURST_LEN_WIDTH  beats per burst; static while busy.
- crs_rid  in  ID_WIDTH  RID driven on all responses.
- m_rvalid  out  1  AXI R valid.
- m_rdata  out  DATA_BITS  AXI R data.
- m_rlast  out  1  AXI R last.
- m_rid  out  ID_WIDTH  AXI R id.
- m_rresp  out  2  AXI R resp (always OKAY, 2'b00).
- m_rready  in  1  AXI R ready from master.
- beatCnt  out  CNT_WIDTH  beats delivered (m_rvalid & m_rready), wraps.
- burstCnt  out  CNT_WIDTH  bursts delivered (handshake with m_rlast), wraps.
- lastErr  out  1  sticky framing error.
- busy  out  1  buffer non-empty or burst in progress.

Behaviour:
- Reset values:
  - all outputs 0, buffer empty, occupancy 0, beat-in-burst counter 0, lastErr 0.
  - m_rid and m_rdata read 0 while empty.
- Buffer: 2 entries {data, last}, registered read/write pointers (1 bit each), occupancy 0..2.
- q_pop = q_valid & (occupancy < 2) & ~(occupancy==1 & m_rvalid & ~m_rready & pendingFill).
  - Simplified rule that is decided: q_pop = q_valid & (occupancy_next_worst < 2), i.e. assert only if a grant can be absorbed even when m_rready=0 this cycle.
  - q_pop is combinational.
- Capture: on the edge where q_pop & q_popGrant, write q_data/q_last (pre-edge values) into buffer[wrPtr]; wrPtr++.
  - Zero-cycle capture; the queue advances at the same edge.
- q_popGrant without q_pop is ignored and causes no write.
- Output: m_rvalid = occupancy != 0; m_rdata/m_rlast = buffer[rdPtr]; m_rid = crs_rid.
  - Data is stable while m_rvalid & ~m_rready (AXI rule).
- Dequeue: on m_rvalid & m_rready, rdPtr++.
- Simultaneous capture and dequeue: occupancy unchanged, both pointers advance.
  - Full-throughput: 1 beat/cycle sustained with m_rready=1.
- Latency: queue beat visible on m_rvalid 1 cycle after grant edge.
- Framing check, beat-in-burst counter bic counted at dequeue:
  - m_rlast=1 with bic != crs_burstLen-1 -> lastErr set.
  - bic == crs_burstLen-1 with m_rlast=0 -> lastErr set.
  - bic resets to 0 on m_rlast handshake, else increments; wraps at 2^BURST_LEN_WIDTH.
  - lastErr cleared only by reset.
- crs_burstLen=0 is treated as 1.
- Counters: beatCnt++ on every R handshake; burstCnt++ on handshake with m_rlast.
- busy = (occupancy != 0) | (bic != 0).
- Reset mid-burst: buffer contents discarded, all state to reset values. No partial burst is completed.

Decomposition:
- Shared package prefetcher_pkg holds:
  - opcode constants OP_NOP=0, OP_RD_REQ_PREF=1, OP_RD_REQ_MASTER=2, OP_RD_DATA_SLAVE=3, OP_RD_DATA_PROMISE=4;
  - error-code constants;
  - AXI RRESP_OKAY.
- One sub-module: r_skid_buffer, a generic 2-entry valid/ready buffer parameterised on payload width. The responder instantiates it with payload {last, data}.

Test Plan:
- Single burst, crs_burstLen=4, q_valid=1, grants every cycle, m_rready=1 -> 4 beats on R, m_rlast on 4th; beatCnt=4, burstCnt=1, lastErr=0.
- Backpressure: m_rready=0 for 5 cycles after first grant -> occupancy reaches 2, q_pop drops to 0, m_rdata held stable; release -> beats delivered in order, no loss or duplication.
- Grant withheld: q_pop=1, q_popGrant=0 for 3 cycles -> no capture, m_rvalid stays 0; grant on 4th cycle -> m_rvalid=1 next cycle.
- Framing error: crs_burstLen=4, q_last=1 on beat 2 -> lastErr=1 after that handshake, stays 1 through following correct bursts.
- Simultaneous capture+dequeue at occupancy 1 for 16 cycles -> 16 beats, occupancy constant 1, throughput 1/cycle.
- Reset asserted with 2 buffered beats mid-burst -> m_rvalid=0, counters 0, lastErr 0 asynchronously. A fresh burst after release completes normally.
